// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mul_sequencer
// Description : Iterative unsigned shift-and-add multiplier controller for the
//               Execute stage; stalls the pipeline while iterating and returns
//               the low or high half of the 2*DATA_WIDTH product.
//               Optional build macro: MUL_EARLY_EXIT_EN (stop once the
//               remaining multiplier bits are all zero).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StartE,
    input  logic                  FlushE,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    input  logic                  MulHighE,
    output logic                  BusyE,
    output logic                  DoneE,
    output logic [DATA_WIDTH-1:0] MulOut
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [2*DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*DATA_WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      high_q, high_d;
    logic [DATA_WIDTH-1:0]     mul_out_q, mul_out_d;

    logic [2*DATA_WIDTH-1:0]   prod_sum;
    logic [DATA_WIDTH-1:0]     mplier_shift;
    logic                      last_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            high_q    <= 1'b0;
            mul_out_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            mul_out_q <= mul_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        high_d       = high_q;
        mul_out_d    = mul_out_q;
        // Carry out of the 2W-bit sum cannot occur for W x W operands.
        prod_sum     = prod_q + (mplier_q[0] ? mcand_q : '0);
        mplier_shift = mplier_q >> 1;
        last_iter    = (cnt_q == CNT_W'(DATA_WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
        last_iter    = last_iter | (mplier_shift == '0);
`endif

        case (state_q)
            ST_IDLE: begin
                if (StartE && !FlushE) begin
                    mcand_d  = {{DATA_WIDTH{1'b0}}, SrcAE};
                    mplier_d = SrcBE;
                    prod_d   = '0;
                    cnt_d    = '0;
                    high_d   = MulHighE;
                    state_d  = ST_RUN;
`ifdef MUL_EARLY_EXIT_EN
                    if (SrcBE == '0) begin
                        state_d   = ST_DONE;
                        mul_out_d = '0;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (FlushE) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d   = prod_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shift;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d   = ST_DONE;
                        mul_out_d = high_q ? prod_sum[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : prod_sum[DATA_WIDTH-1:0];
                    end
                end
            end
            ST_DONE: begin
                // StartE is deliberately ignored here; requester re-asserts in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BusyE  = !rst && ((state_q == ST_RUN) ||
                             ((state_q == ST_IDLE) && StartE && !FlushE));
    assign DoneE  = !rst && (state_q == ST_DONE) && !FlushE;
    assign MulOut = mul_out_q;

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative unsigned shift-and-add multiply controller sitting alongside the ALU in the Execute stage. It accepts one multiply request from the pipeline, sequences DATA_WIDTH add/shift iterations through an internal adder, holds the pipeline with a stall signal while busy, and returns either the low or high half of the 2*DATA_WIDTH product. The hazard unit ORs BusyE into its Execute-stage stall term. Single-cycle ALU operations do not pass through this block.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- StartE  input  1  multiply request, valid with operands; sampled only in IDLE
- FlushE  input  1  abort current operation (branch flush); synchronous
- SrcAE  input  DATA_WIDTH  multiplicand (unsigned)
- SrcBE  input  DATA_WIDTH  multiplier (unsigned)
- MulHighE  input  1  0: return product[W-1:0]; 1: return product[2W-1:W]; latched at start
- BusyE  output  1  stall request to hazard unit
- DoneE  output  1  one-cycle pulse: MulOut valid
- MulOut  output  DATA_WIDTH  result register; holds last result until next DONE

## Operation
- States: IDLE, RUN, DONE. Internal regs: multiplicand (2W bits), multiplier (W), product (2W), iteration counter (clog2(W)+1 bits), latched MulHighE.
- IDLE: StartE=1 and FlushE=0 -> load multiplicand={W'0,SrcAE}, multiplier=SrcBE, product=0, counter=0, latch MulHighE; go RUN. Otherwise stay.
- RUN, per cycle: if multiplier[0] then product <= product + multiplicand (2W-bit add, carry out of 2W discarded, cannot occur); multiplicand <<= 1; multiplier >>= 1; counter++. When counter==W-1 in this cycle -> DONE.
- DONE: MulOut <= selected half of product (registered on entry, visible during DONE); DoneE=1; next state IDLE unconditionally. StartE in DONE is ignored; requester must re-assert in IDLE.
- FlushE=1 in RUN or DONE -> IDLE next cycle; MulOut unchanged, DoneE forced 0 that cycle. FlushE dominates StartE in IDLE.
- BusyE = (state==RUN) | (state==IDLE & StartE & ~FlushE); combinational, 0 while rst=1. BusyE is 0 in DONE so the pipeline advances with MulOut that cycle.
- Reset (any state, including mid-RUN): state IDLE, MulOut=0, DoneE=0, all internal regs 0.

## Timing
- Start accepted at edge 0 (cycle BusyE first high); RUN occupies W cycles; DONE (DoneE=1, MulOut valid) in cycle W+1 after acceptance. Default W=32 -> DoneE 33 cycles after StartE sampled.
- Minimum start-to-start spacing: W+2 cycles (IDLE, W×RUN, DONE).
- MulOut changes only on entry to DONE; stable otherwise.

## Configuration
- MUL_EARLY_EXIT_EN defined: RUN also exits to DONE when the post-shift multiplier is zero; IDLE goes directly to DONE if SrcBE==0 (product 0). Latency = (index of highest set bit of SrcBE)+2 cycles, minimum 1 (B=0). Result identical to full iteration.
- Undefined: fixed W-cycle RUN regardless of operands; latency always W+1.

## Test plan
- SrcAE=3, SrcBE=5, MulHighE=0, StartE one cycle -> BusyE high 33 cycles, DoneE pulse at cycle 33, MulOut=15; BusyE 0 in DONE.
- SrcAE=SrcBE=0xFFFFFFFF, MulHighE=1 -> MulOut=0xFFFFFFFE; repeat with MulHighE=0 -> MulOut=0x00000001.
- Start 3×5, FlushE at RUN cycle 10 -> IDLE next cycle, no DoneE, MulOut keeps prior value, BusyE drops; new start 2×4 then gives MulOut=8.
- rst pulsed mid-RUN -> MulOut=0, DoneE=0, BusyE=0 next cycle; StartE held high through DONE of a prior op -> second op starts only after IDLE re-entered.
- MUL_EARLY_EXIT_EN: 7×1 -> DoneE 2 cycles after start, MulOut=7; 9×0 -> DoneE 1 cycle after start, MulOut=0; without macro 7×1 takes 33 cycles.
- Back-to-back: StartE held continuously with 6×7 -> results 42 with DoneE pulses exactly 34 cycles apart.
